servo_pwm_decoder: RTL
======================

Name: servo_pwm_decoder

Overview:
- Receive side of the servo PWM link: measures the high time of each hobby-servo pulse on one input and converts it to the same 8-bit angle code the servo driver consumes.
- Used to read an RC receiver channel or to loop back a servo leg output for self-test.
- Reports each accepted angle with a one-cycle strobe, flags out-of-range pulses, and flags signal loss.

Parameters:
- STEP_CYC, 47: clock cycles per width tick (12 MHz clock, about 3.92 us per tick).
- OFFSET_TICKS, 255: tick count that maps to angle 0 (1.0 ms).
- MIN_VALID_TICKS, 200: pulses with fewer ticks are rejected (about 0.78 ms).
- MAX_VALID_TICKS, 600: pulses with more ticks are rejected (about 2.35 ms).
- TIMEOUT_CYC, 300000: clocks without a rising edge before `lost` asserts (25 ms).

Ports:
- clk, in, 1: system clock, 12 MHz.
- rst, in, 1: asynchronous active-low reset.
- servo_in, in, 1: raw asynchronous PWM input.
- angle, out, 8: last accepted angle code.
- angle_stb, out, 1: one-cycle pulse when `angle` updates.
- err, out, 1: one-cycle pulse when a completed pulse is rejected.
- lost, out, 1: level; high while the signal is considered absent.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - synchronizer flops to 0; state to ARM;
  - `angle`, `angle_stb`, `err` to 0; `lost` to 1;
  - tick, prescaler and watchdog counters to 0.
- Input conditioning:
  - 2-flop synchronizer on `servo_in`, then a third flop for edge detection.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Both edges carry the same 3-cycle delay, so measured width equals raw width.
- FSM, state ARM:
  - Wait for synced low (a pulse already in progress at reset exit is never measured); then go to IDLE.
- FSM, state IDLE:
  - On rise: clear the prescaler and tick counter, go to HIGH.
- FSM, state HIGH:
  - Prescaler counts 0..STEP_CYC-1; each wrap increments the tick counter.
  - Tick counter is 10 bits and saturates at 1023; a partial final step is discarded (floor).
  - On fall: go to EVAL.
- FSM, state EVAL (one cycle):
  - If ticks < MIN_VALID_TICKS or ticks > MAX_VALID_TICKS: assert `err`; `angle` unchanged.
  - Otherwise: angle = clamp(ticks - OFFSET_TICKS, 0, 255), assert `angle_stb`, clear `lost`.
  - Go to IDLE.
- Latency: `angle_stb` asserts exactly 4 clocks after the raw falling edge (3 sync/edge plus 1 EVAL).
- Watchdog counter:
  - Cleared on every synced rise; otherwise increments, saturating at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC sets `lost`=1. `angle` holds its last value.
  - FSM state is unaffected, except that a stuck-high input saturates ticks and yields `err` on its eventual fall.
- Simultaneous events:
  - Acceptance and timeout in the same cycle: acceptance wins, `lost`=0.
  - `angle_stb` and `err` are mutually exclusive.
- Reset asserted mid-pulse: all state clears immediately; after release the FSM re-arms via ARM.

Decomposition:
- Shared package:
  - FSM state encoding (ARM, IDLE, HIGH, EVAL).
  - Angle width constant, 8.
  - Tick counter width constant, 10.
- Natural sub-module: `sync_edge`.
  - Contains the 2-flop synchronizer plus edge flop; outputs level, rise, fall.
  - Reusable for the IR sensor inputs.

Test Plan:
- 1.5 ms pulse (18000 cycles high), 20 ms period -> ticks 382, `angle`=127, `angle_stb` 4 clocks after the fall, `lost` deasserts.
- 1.0 ms (12000 cycles) -> angle 0; 2.0 ms (24000 cycles) -> angle 255; 0.9 ms (10800 cycles, ticks 229) -> clamped to 0 with `angle_stb`.
- 0.5 ms (6000 cycles, ticks 127) and 3.0 ms (36000 cycles, ticks 765) -> `err` one-cycle pulse, no `angle_stb`, `angle` keeps its previous value.
- Valid pulses, then input held low for 300000 cycles -> `lost`=1 on the TIMEOUT_CYC-th cycle, `angle` held; next 1.5 ms pulse -> `lost`=0 together with `angle_stb`.
- Reset released while `servo_in` is high mid-pulse -> no `angle_stb`/`err` for that pulse; the following full 1.5 ms pulse yields angle 127.
- Input stuck high 40 ms then falls -> ticks saturate at 1023 -> `err`; `lost` asserts 25 ms after the last rise.

Source files
------------

// File: rtl/servo_pwm_decoder_pkg.sv
// Shared types and constants for the servo PWM receive path.
package servo_pwm_decoder_pkg;

  localparam int ANGLE_W = 8;
  localparam int TICK_W  = 10;

  // Cycles ARM waits after reset for the synchronizer and edge flop to fill.
  localparam logic [1:0] ARM_FILL = 2'd3;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_EVAL = 2'd3
  } state_t;

  // Convert a measured tick count into an angle code: ticks below or equal
  // to the offset map to 0, and anything beyond the 8-bit range saturates.
  function automatic logic [ANGLE_W-1:0] ticks_to_angle(
    input logic [TICK_W-1:0] ticks,
    input logic [TICK_W-1:0] offset
  );
    logic [TICK_W-1:0] diff;
    logic [TICK_W-1:0] limit;
    logic [ANGLE_W-1:0] res;
    limit = TICK_W'((1 << ANGLE_W) - 1);
    diff  = ticks - offset;
    if (ticks <= offset) begin
      res = '0;
    end else if (diff > limit) begin
      res = '1;
    end else begin
      res = diff[ANGLE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_decoder_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect flop.
// Rising and falling edges both appear with the same latency, so pulse
// widths measured from rise/fall equal the raw input widths.
module servo_pwm_decoder_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronize the asynchronous input and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receive decoder: measures pulse high time in ticks of STEP_CYC
// clocks and converts it to the 8-bit angle code used by the servo driver.
//
// Output semantics: angle_stb is a single-cycle valid with no ready; angle
// changes only in the cycle angle_stb is high and holds otherwise. err is a
// single-cycle flag for a rejected pulse and never coincides with angle_stb.
// lost is a level that rises after TIMEOUT_CYC clocks without a rising edge
// and falls with the next accepted angle. The FSM state is held in state_q.
module servo_pwm_decoder
  import servo_pwm_decoder_pkg::*;
#(
  parameter int unsigned STEP_CYC        = 47,
  parameter int unsigned OFFSET_TICKS    = 255,
  parameter int unsigned MIN_VALID_TICKS = 200,
  parameter int unsigned MAX_VALID_TICKS = 600,
  parameter int unsigned TIMEOUT_CYC     = 300000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               servo_in,
  output logic [ANGLE_W-1:0] angle,
  output logic               angle_stb,
  output logic               err,
  output logic               lost
);

  localparam int PW   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0]     PRESC_LAST = PW'(STEP_CYC - 1);
  localparam logic [TICK_W-1:0] TICK_MAX   = '1;
  localparam logic [TICK_W-1:0] MIN_T      = TICK_W'(MIN_VALID_TICKS);
  localparam logic [TICK_W-1:0] MAX_T      = TICK_W'(MAX_VALID_TICKS);
  localparam logic [TICK_W-1:0] OFFSET_T   = TICK_W'(OFFSET_TICKS);
  localparam logic [WD_W-1:0]   WD_MAX     = WD_W'(TIMEOUT_CYC);

  logic level;
  logic rise;
  logic fall;

  state_t              state_q,   state_d;
  logic [1:0]          arm_cnt_q, arm_cnt_d;
  logic [PW-1:0]       presc_q,   presc_d;
  logic [TICK_W-1:0]   ticks_q,   ticks_d;
  logic [WD_W-1:0]     wd_q,      wd_d;
  logic [ANGLE_W-1:0]  angle_q,   angle_d;
  logic                stb_q,     stb_d;
  logic                err_q,     err_d;
  logic                lost_q,    lost_d;
  logic                accept;

  servo_pwm_decoder_sync_edge u_sync_edge (
    .clk   (clk),
    .rst_n (rst),
    .d_in  (servo_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Pulse measurement FSM: arm, wait for rise, count ticks while high, judge.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    presc_d   = presc_q;
    ticks_d   = ticks_q;
    angle_d   = angle_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_ARM: begin
        // Let the synchronizer fill first, so a pulse in progress at reset
        // exit is seen as high and skipped rather than measured.
        if (arm_cnt_q != ARM_FILL) begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end else if (!level) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          presc_d = '0;
          ticks_d = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (ticks_q != TICK_MAX) begin
            ticks_d = ticks_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (fall) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if ((ticks_q < MIN_T) || (ticks_q > MAX_T)) begin
          err_d = 1'b1;
        end else begin
          angle_d = ticks_to_angle(ticks_q, OFFSET_T);
          stb_d   = 1'b1;
          accept  = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_ARM;
    endcase
  end

  // Signal-loss watchdog; an acceptance in the same cycle overrides timeout.
  always_comb begin
    if (rise) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
    lost_d = lost_q;
    if (wd_d == WD_MAX) begin
      lost_d = 1'b1;
    end
    if (accept) begin
      lost_d = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_ARM;
      arm_cnt_q <= '0;
      presc_q   <= '0;
      ticks_q   <= '0;
      wd_q      <= '0;
      angle_q   <= '0;
      stb_q     <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      presc_q   <= presc_d;
      ticks_q   <= ticks_d;
      wd_q      <= wd_d;
      angle_q   <= angle_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
    end
  end

  assign angle     = angle_q;
  assign angle_stb = stb_q;
  assign err       = err_q;
  assign lost      = lost_q;

endmodule
